register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised successor to the 32x32 CPU register file, for the pipelined datapath. It provides configurable width and depth, a write enable, and a hardwired zero register. It adds two behaviours the previous file lacked: same-cycle write-to-read bypass and a per-register pending-write scoreboard, which the hazard unit uses to stall consumers of in-flight results. It sits between decode (reads, issue) and writeback (write).

## Interface
Parameters:
- WIDTH, 32, data width per register
- DEPTH, 32, number of registers (2..64; need not be a power of two)
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, never goes busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports
- AW (localparam), $clog2(DEPTH), address width

Ports (all single-bit unless stated):
- Clk  in  1  single clock, rising edge
- Clr  in  1  asynchronous, active-high reset
- RS  in  AW  read address A
- RT  in  AW  read address B
- dataRS  out  WIDTH  read data A
- dataRT  out  WIDTH  read data B
- busyRS  out  1  register RS has a pending write
- busyRT  out  1  register RT has a pending write
- RD  in  AW  write address
- dataRD  in  WIDTH  write data
- WE  in  1  write enable
- IssueValid  in  1  an instruction producing IssueRD is issued this cycle
- IssueRD  in  AW  destination of the issued instruction
- PendCount  out  AW+1  number of registers currently busy

## Operation
- Write: at a rising Clk edge with WE=1 and RD a valid address, reg[RD] <= dataRD. No write occurs if RD=0 with ZERO_REG=1, or if RD>=DEPTH.
- Read: combinational. Addresses >=DEPTH read 0. With ZERO_REG=1, address 0 reads 0.
- Bypass: with BYPASS=1, WE=1 and RD==RS (valid, non-zero when ZERO_REG), dataRS=dataRD in the same cycle. dataRT follows the same rule.
- Scoreboard: busy[DEPTH-1:0]. At a Clk edge:
  - IssueValid sets busy[IssueRD].
  - A qualifying write clears busy[RD].
  - If issue and write hit the same register, set wins (a newer producer is in flight).
  - Invalid or zero addresses are ignored.
- busyRS = busy[RS] & ~(WE & RD==RS). This applies with or without BYPASS, since the write makes the value current. busyRT follows the same rule.
- The effect of a same-cycle issue appears on busyRS/busyRT from the next cycle.
- PendCount is the popcount of busy, registered and updated with busy. Its maximum is DEPTH-1 with ZERO_REG=1, otherwise DEPTH. It never wraps.
- A write to a non-busy register is legal (no scoreboard change). A second issue to an already busy register is legal (bit stays set).

## Timing
- Clr asserted: all registers, busy bits and PendCount go to 0 immediately, independent of Clk. Outputs are then dataRS/dataRT=0, busyRS/busyRT=0 and PendCount=0.
- Clr deasserted: the first capturing edge is the next rising Clk edge.
- Clr asserted mid-operation: pending writes that cycle are lost and all busy bits clear.
- Write latency: 1 edge. Without bypass, read data reflects the write from the cycle after the edge.
- Issue-to-busy latency: 1 edge. Write-to-not-busy latency: 0 cycles (combinational mask), with the bit clearing at the edge.
- No handshake: every request is accepted every cycle.

## Structure
- Shared package: default WIDTH/DEPTH constants and a regfile address type, sized to the CPU's 5-bit register fields.
- Sub-module regfile_scoreboard: busy vector, set/clear priority, popcount register and busy lookups for two addresses. It takes Clk, Clr, issue and write strobes.
- The top holds the storage array, the read muxes and the bypass.

## Test plan
- Reset: load reg[5]=0xDEADBEEF and issue 5, then pulse Clr mid-cycle -> dataRS(RS=5)=0, busyRS=0 and PendCount=0 at once, before any Clk edge.
- Write/read: WE, RD=7, dataRD=0x12345678, then the next cycle RS=7, RT=7 -> both read 0x12345678. With BYPASS=1 the same value appears in the write cycle; with BYPASS=0 the old value 0 appears.
- Zero register: WE, RD=0, dataRD=0xFFFFFFFF and IssueValid, IssueRD=0 -> RS=0 reads 0, busyRS=0, PendCount unchanged.
- Scoreboard: issue 3, issue 9, then write 3 -> PendCount goes 1, 2, 1. busyRS(RS=3) is 0 in the write cycle, and busyRT(RT=9) stays 1.
- Simultaneous: IssueRD=4 and WE, RD=4 in the same cycle with busy[4]=1 -> in that cycle busyRS(RS=4)=0 and the data is bypassed. On the next cycle busy[4]=1 and PendCount is unchanged.
- Range: DEPTH=24, RS=30 -> dataRS=0. WE with RD=30 leaves all registers unchanged, and IssueRD=30 leaves PendCount unchanged.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared defaults, address type and address qualification for the
// pipelined register file and its pending-write scoreboard.
package register_file_sb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int ADDR_BITS = 5;

    typedef logic [ADDR_BITS-1:0] reg_addr_t;

    // An address takes part in writes, issues and reads only when it names
    // a real register that is not the hardwired zero register.
    function automatic logic addr_ok(
        input int addr,
        input int depth,
        input bit zero_reg
    );
        addr_ok = (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, with a registered popcount.
module regfile_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_rd,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          busy_rs,
    output logic          busy_rt,
    output logic [AW:0]   pend_count
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      pend_q;
    logic [AW:0]      pend_d;
    logic             issue_ok;
    logic             wr_ok;
    logic             rs_ok;
    logic             rt_ok;

    always_comb begin
        issue_ok = issue_valid && addr_ok(int'(issue_rd), DEPTH, ZERO_REG);
        wr_ok    = wr_en && addr_ok(int'(wr_rd), DEPTH, ZERO_REG);
        busy_d   = busy_q;
        if (wr_ok) begin
            busy_d[wr_rd] = 1'b0;
        end
        // A newer producer issued in the same cycle keeps the bit set.
        if (issue_ok) begin
            busy_d[issue_rd] = 1'b1;
        end
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_d = pend_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    // A write landing this cycle makes the value current, so it masks busy.
    always_comb begin
        rs_ok   = addr_ok(int'(rs), DEPTH, ZERO_REG);
        rt_ok   = addr_ok(int'(rt), DEPTH, ZERO_REG);
        busy_rs = 1'b0;
        busy_rt = 1'b0;
        if (rs_ok) begin
            busy_rs = busy_q[rs] && !(wr_en && (wr_rd == rs));
        end
        if (rt_ok) begin
            busy_rt = busy_q[rt] && !(wr_en && (wr_rd == rt));
        end
    end

    assign pend_count = pend_q;

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with zero register, same-cycle write bypass
// and a pending-write scoreboard for the hazard unit.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [AW-1:0]    RS,
    input  logic [AW-1:0]    RT,
    output logic [WIDTH-1:0] dataRS,
    output logic [WIDTH-1:0] dataRT,
    output logic             busyRS,
    output logic             busyRT,
    input  logic [AW-1:0]    RD,
    input  logic [WIDTH-1:0] dataRD,
    input  logic             WE,
    input  logic             IssueValid,
    input  logic [AW-1:0]    IssueRD,
    output logic [AW:0]      PendCount
);

    typedef logic [WIDTH-1:0] word_t;

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];
    logic  wr_ok;
    logic  fwd_ok;
    logic  rs_ok;
    logic  rt_ok;

    always_comb begin
        wr_ok = WE && addr_ok(int'(RD), DEPTH, ZERO_REG);
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[RD] = dataRD;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Forwarding is held off during reset so outputs read zero at once.
    always_comb begin
        fwd_ok = BYPASS && wr_ok && !Clr;
        rs_ok  = addr_ok(int'(RS), DEPTH, ZERO_REG);
        rt_ok  = addr_ok(int'(RT), DEPTH, ZERO_REG);
        dataRS = '0;
        dataRT = '0;
        if (rs_ok) begin
            if (fwd_ok && (RD == RS)) begin
                dataRS = dataRD;
            end else begin
                dataRS = mem_q[RS];
            end
        end
        if (rt_ok) begin
            if (fwd_ok && (RD == RT)) begin
                dataRT = dataRD;
            end else begin
                dataRT = mem_q[RT];
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .Clk         (Clk),
        .Clr         (Clr),
        .issue_valid (IssueValid),
        .issue_rd    (IssueRD),
        .wr_en       (WE),
        .wr_rd       (RD),
        .rs          (RS),
        .rt          (RT),
        .busy_rs     (busyRS),
        .busy_rt     (busyRT),
        .pend_count  (PendCount)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench: three instances (bypass, no bypass, depth 24) share
// one stimulus stream; expectations are queued and checked by a monitor.
module tb_register_file_sb;

    logic        clk;
    logic        clr;
    logic [4:0]  rs, rt, rd, ird;
    logic [31:0] wdata;
    logic        we, iv;

    logic [31:0] b_rs, b_rt, n_rs, n_rt, r_rs, r_rt;
    logic        b_brs, b_brt, n_brs, n_brt, r_brs, r_brt;
    logic [5:0]  b_pc, n_pc, r_pc;

    register_file_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_b (
        .Clk(clk), .Clr(clr), .RS(rs), .RT(rt), .dataRS(b_rs), .dataRT(b_rt),
        .busyRS(b_brs), .busyRT(b_brt), .RD(rd), .dataRD(wdata), .WE(we),
        .IssueValid(iv), .IssueRD(ird), .PendCount(b_pc)
    );

    register_file_sb #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u_n (
        .Clk(clk), .Clr(clr), .RS(rs), .RT(rt), .dataRS(n_rs), .dataRT(n_rt),
        .busyRS(n_brs), .busyRT(n_brt), .RD(rd), .dataRD(wdata), .WE(we),
        .IssueValid(iv), .IssueRD(ird), .PendCount(n_pc)
    );

    register_file_sb #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1), .BYPASS(1)) u_r (
        .Clk(clk), .Clr(clr), .RS(rs), .RT(rt), .dataRS(r_rs), .dataRT(r_rt),
        .busyRS(r_brs), .busyRT(r_brt), .RD(rd), .dataRD(wdata), .WE(we),
        .IssueValid(iv), .IssueRD(ird), .PendCount(r_pc)
    );

    typedef enum int {
        B_DRS, B_DRT, B_BRS, B_BRT, B_PC,
        N_DRS, N_DRT, N_BRS, N_PC,
        R_DRS, R_DRT, R_PC
    } sel_t;

    typedef struct {
        sel_t        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input sel_t s);
        case (s)
            B_DRS:   observe = b_rs;
            B_DRT:   observe = b_rt;
            B_BRS:   observe = {31'd0, b_brs};
            B_BRT:   observe = {31'd0, b_brt};
            B_PC:    observe = {26'd0, b_pc};
            N_DRS:   observe = n_rs;
            N_DRT:   observe = n_rt;
            N_BRS:   observe = {31'd0, n_brs};
            N_PC:    observe = {26'd0, n_pc};
            R_DRS:   observe = r_rs;
            R_DRT:   observe = r_rt;
            R_PC:    observe = {26'd0, r_pc};
            default: observe = 32'hxxxx_xxxx;
        endcase
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = observe(e.sel);
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h want 0x%08h at %0t",
                             e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_v(input sel_t s, input logic [31:0] v, input string n);
        exp_t e;
        e.sel  = s;
        e.exp  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic sample();
        #2;
        ->sample_ev;
        #1;
    endtask

    task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic i, input logic [4:0] ia,
                       input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        we    = w;
        rd    = a;
        wdata = d;
        iv    = i;
        ird   = ia;
        rs    = ra;
        rt    = rb;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        clr = 1'b1;
        we = 0; rd = 0; wdata = 0; iv = 0; ird = 0; rs = 5; rt = 0;
        expect_v(B_DRS, 0, "rst_data");
        expect_v(B_BRS, 0, "rst_busy");
        expect_v(B_PC, 0, "rst_pc_b");
        expect_v(N_PC, 0, "rst_pc_n");
        expect_v(R_PC, 0, "rst_pc_r");
        sample();
        @(negedge clk);
        clr = 1'b0;

        // write and issue r5 together; bypass visible only on u_b
        cyc(1, 5, 32'hDEADBEEF, 1, 5, 5, 0);
        expect_v(B_DRS, 32'hDEADBEEF, "byp_r5");
        expect_v(N_DRS, 0, "nobyp_r5");
        expect_v(B_BRS, 0, "busy5_pre");
        sample();

        cyc(0, 0, 0, 0, 0, 5, 0);
        expect_v(B_DRS, 32'hDEADBEEF, "r5_stored");
        expect_v(B_BRS, 1, "busy5_set");
        expect_v(B_PC, 1, "pc_r5");
        sample();
        #1 clr = 1'b1;
        expect_v(B_DRS, 0, "mid_rst_data");
        expect_v(N_DRS, 0, "mid_rst_data_n");
        expect_v(B_BRS, 0, "mid_rst_busy");
        expect_v(B_PC, 0, "mid_rst_pc");
        expect_v(R_PC, 0, "mid_rst_pc_r");
        sample();
        #1 clr = 1'b0;

        cyc(1, 7, 32'h12345678, 0, 0, 7, 7);
        expect_v(B_DRS, 32'h12345678, "byp_rs7");
        expect_v(B_DRT, 32'h12345678, "byp_rt7");
        expect_v(N_DRS, 0, "old_rs7");
        expect_v(N_DRT, 0, "old_rt7");
        sample();

        cyc(0, 0, 0, 0, 0, 7, 7);
        expect_v(N_DRS, 32'h12345678, "rd_rs7_n");
        expect_v(N_DRT, 32'h12345678, "rd_rt7_n");
        expect_v(B_DRS, 32'h12345678, "rd_rs7_b");
        sample();

        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        expect_v(B_DRS, 0, "zero_byp");
        expect_v(B_BRS, 0, "zero_busy");
        expect_v(B_PC, 0, "zero_pc0");
        sample();

        cyc(0, 0, 0, 0, 0, 0, 0);
        expect_v(B_DRS, 0, "zero_rd_b");
        expect_v(N_DRS, 0, "zero_rd_n");
        expect_v(B_BRS, 0, "zero_busy1");
        expect_v(B_PC, 0, "zero_pc1");
        sample();

        cyc(0, 0, 0, 1, 3, 3, 9);
        expect_v(B_BRS, 0, "iss3_lat");
        expect_v(B_PC, 0, "iss3_pc");
        sample();

        cyc(0, 0, 0, 1, 9, 3, 9);
        expect_v(B_BRS, 1, "busy3");
        expect_v(B_BRT, 0, "iss9_lat");
        expect_v(B_PC, 1, "pc_1");
        sample();

        cyc(1, 3, 32'h33, 0, 0, 3, 9);
        expect_v(B_BRS, 0, "wr3_mask");
        expect_v(N_BRS, 0, "wr3_mask_n");
        expect_v(B_BRT, 1, "busy9");
        expect_v(B_PC, 2, "pc_2");
        expect_v(B_DRS, 32'h33, "byp_r3");
        expect_v(N_DRS, 0, "old_r3");
        sample();

        cyc(0, 0, 0, 0, 0, 3, 9);
        expect_v(B_PC, 1, "pc_back1");
        expect_v(B_BRS, 0, "busy3_clr");
        expect_v(B_BRT, 1, "busy9_hold");
        expect_v(N_DRS, 32'h33, "rd_r3_n");
        sample();

        cyc(0, 0, 0, 1, 4, 4, 9);
        expect_v(B_PC, 1, "iss4_pc");
        sample();

        cyc(1, 4, 32'h44, 1, 4, 4, 9);
        expect_v(B_BRS, 0, "sim4_mask");
        expect_v(B_DRS, 32'h44, "sim4_byp");
        expect_v(N_DRS, 0, "sim4_old");
        expect_v(B_PC, 2, "sim4_pc");
        sample();

        cyc(0, 0, 0, 0, 0, 4, 9);
        expect_v(B_BRS, 1, "sim4_setwin");
        expect_v(B_PC, 2, "sim4_pc_next");
        expect_v(B_DRS, 32'h44, "r4_stored");
        sample();

        cyc(1, 30, 32'hAAAA5555, 1, 30, 30, 4);
        expect_v(R_DRS, 0, "rng_rd30");
        expect_v(R_PC, 2, "rng_pc");
        expect_v(B_DRS, 32'hAAAA5555, "r30_byp_b");
        expect_v(B_PC, 2, "r30_pc_b");
        sample();

        cyc(0, 0, 0, 0, 0, 30, 4);
        expect_v(R_DRS, 0, "rng_rd30_next");
        expect_v(R_DRT, 32'h44, "rng_r4_kept");
        expect_v(R_PC, 2, "rng_pc_next");
        expect_v(B_PC, 3, "r30_pc_b_next");
        expect_v(B_DRS, 32'hAAAA5555, "r30_stored_b");
        sample();

        cyc(1, 31, 32'h31313131, 0, 0, 31, 0);
        sample();
        cyc(0, 0, 0, 0, 0, 31, 0);
        expect_v(N_DRS, 32'h31313131, "top_reg31");
        sample();

        #5;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
